// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: front-panel button/switch inputs and the counter-control
// outputs of stopwatch_ctrl. The slave modport is the controller's view; the
// master modport is the view of whatever drives the panel and reads the controls.
interface stopwatch_ctrl_if;
  logic strtstop;
  logic rst_btn;
  logic load_btn;
  logic mode;
  logic ce;
  logic cnt_clr;
  logic load;
  logic up;
  logic running;

  modport master (
    output strtstop, rst_btn, load_btn, mode,
    input  ce, cnt_clr, load, up, running
  );

  modport slave (
    input  strtstop, rst_btn, load_btn, mode,
    output ce, cnt_clr, load, up, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, stopwatch state machine and 100 Hz
// count-enable prescaler feeding the stopwatch time counter. All outputs are
// registered. Define STOPWATCH_COUNTDOWN_EN to build the preset-load button,
// the load pulse and the mode-controlled count direction; without it load is
// tied 0 and up is tied 1.

// Per-button conditioner: 2-flop synchroniser, restartable debounce counter,
// one-cycle press pulse on the debounced rising edge.
module stopwatch_db #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level after DB_CYCLES consecutive samples
  // that disagree with the current one; any sample agreeing with the current
  // level restarts the count.
  // NOTE: registers use non-blocking assignments so every flop samples values
  // from before the edge; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 500_000
) (
  input logic             clk,
  input logic             clr,
  stopwatch_ctrl_if.slave sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  typedef enum logic [1:0] {S_CLEAR, S_ZERO, S_RUN, S_STOP} state_t;

  state_t        state;
  logic          rst_hold;   // extends CLEAR by one edge on leaving reset
  logic [PW-1:0] presc;
  logic          ce_q;
  logic          cnt_clr_q;
  logic          running_q;
  logic          ss_press;
  logic          rb_press;

  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .clr   (clr),
    .btn   (sw.strtstop),
    .press (ss_press)
  );

  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_rb (
    .clk   (clk),
    .clr   (clr),
    .btn   (sw.rst_btn),
    .press (rb_press)
  );

`ifdef STOPWATCH_COUNTDOWN_EN
  logic ld_press;
  logic load_q;
  logic up_q;

  stopwatch_db #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
    .clk   (clk),
    .clr   (clr),
    .btn   (sw.load_btn),
    .press (ld_press)
  );

  // Direction follows the switch only while the counter is idle, so a mode
  // change during RUN waits for the next stop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      up_q <= 1'b1;
    end else if (state == S_ZERO || state == S_STOP) begin
      up_q <= ~sw.mode;
    end
  end

  assign sw.load = load_q;
  assign sw.up   = up_q;
`else
  logic unused_inputs;
  assign unused_inputs = sw.load_btn ^ sw.mode;
  assign sw.load = 1'b0;
  assign sw.up   = 1'b1;
`endif

  // State machine with prescaler; outputs are registered from the decision
  // taken at each edge. Priority in STOP: rst_btn > strtstop > load_btn.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_CLEAR;
      rst_hold  <= 1'b1;
      presc     <= '0;
      ce_q      <= 1'b0;
      cnt_clr_q <= 1'b1;
      running_q <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      load_q    <= 1'b0;
`endif
    end else begin
      rst_hold  <= 1'b0;
      presc     <= '0;
      ce_q      <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      load_q    <= 1'b0;
`endif
      case (state)
        S_CLEAR: begin
          if (rst_hold) begin
            cnt_clr_q <= 1'b1;
          end else begin
            state <= S_ZERO;
          end
        end
        S_ZERO: begin
          if (ss_press) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
`ifdef STOPWATCH_COUNTDOWN_EN
          else if (ld_press) begin
            state  <= S_STOP;
            load_q <= 1'b1;
          end
`endif
        end
        S_RUN: begin
          // A stop on the terminal count wins: no ce, prescaler back to 0.
          if (ss_press) begin
            state <= S_STOP;
          end else begin
            running_q <= 1'b1;
            if (presc == PW'(DIV - 1)) begin
              ce_q <= 1'b1;
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        S_STOP: begin
          if (rb_press) begin
            state     <= S_CLEAR;
            cnt_clr_q <= 1'b1;
          end else if (ss_press) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
`ifdef STOPWATCH_COUNTDOWN_EN
          else if (ld_press) begin
            load_q <= 1'b1;
          end
`endif
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign sw.ce      = ce_q;
  assign sw.cnt_clr = cnt_clr_q;
  assign sw.running = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model of the
// stopwatch controller (sliding-window debounce, elapsed-cycle tick rule).
module tb_stopwatch_ctrl;
  localparam int DIV = 10;
  localparam int DB  = 4;
`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .clr (clr),
    .sw  (sw)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic exp_ce, exp_cnt_clr, exp_load, exp_up, exp_running;
  bit   m_clearing, m_first, m_running, m_stopped;
  int   m_run_cycles;
  logic hist [3][DB+2];
  bit   lvl [3];
  bit   pressed [3];

  task automatic model_reset();
    exp_ce = 0; exp_cnt_clr = 1; exp_load = 0; exp_up = 1; exp_running = 0;
    m_clearing = 1; m_first = 1; m_running = 0; m_stopped = 0; m_run_cycles = 0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 0;
      pressed[b] = 0;
      for (int i = 0; i < DB + 2; i++) hist[b][i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit   was_idle;
    logic raw [3];
    raw[0] = sw.strtstop;
    raw[1] = sw.rst_btn;
    raw[2] = sw.load_btn;
    was_idle = !m_clearing && !m_running;
    exp_ce = 0; exp_load = 0; exp_cnt_clr = 0;
    if (m_clearing) begin
      if (m_first) begin
        m_first = 0;
        exp_cnt_clr = 1;
      end else begin
        m_clearing = 0;
        m_stopped = 0;
      end
    end else if (m_running) begin
      if (pressed[0]) begin
        m_running = 0;
        m_stopped = 1;
      end else begin
        m_run_cycles++;
        exp_ce = (m_run_cycles % DIV == 0);
      end
    end else if (m_stopped && pressed[1]) begin
      m_clearing = 1;
      exp_cnt_clr = 1;
    end else if (pressed[0]) begin
      m_running = 1;
      m_run_cycles = 0;
    end else if (CD_EN && pressed[2]) begin
      m_stopped = 1;
      exp_load = 1;
    end
    if (CD_EN && was_idle) exp_up = ~sw.mode;
    exp_running = m_running;
    // A button level is accepted once the last DB synchronised samples all
    // disagree with it; hist[b][2] is the sample leaving the synchroniser.
    for (int b = 0; b < 3; b++) begin
      bit flip;
      for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = raw[b];
      flip = 1;
      for (int i = 2; i <= DB + 1; i++) if (hist[b][i] == lvl[b]) flip = 0;
      pressed[b] = 0;
      if (flip) begin
        lvl[b] = ~lvl[b];
        pressed[b] = lvl[b];
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge clr);
      if (clr) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("ce", sw.ce, exp_ce);
    check("cnt_clr", sw.cnt_clr, exp_cnt_clr);
    check("load", sw.load, exp_load);
    check("up", sw.up, exp_up);
    check("running", sw.running, exp_running);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ce(output bit seen);
    seen = 0;
    for (int k = 0; k < 3 * DIV && !seen; k++) begin
      step();
      seen = sw.ce;
    end
  endtask

  // Hold a button (or two) high for 10 cycles within a 20-cycle window.
  task automatic press_ss();
    sw.strtstop = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) sw.strtstop = 0;
    end
  endtask

  int rise, first_ce, n_ce, n_clr, clr_at, n_run, n_load, load_at;
  int ce_at [4];
  bit seen;
  int h_ss, h_rb, h_lb;

  initial begin
    sw.strtstop = 0; sw.rst_btn = 0; sw.load_btn = 0; sw.mode = 0;
    #1 clr = 1;
    repeat (3) step();
    check("rst_cnt_clr", sw.cnt_clr, 1);
    check("rst_ce", sw.ce, 0);
    check("rst_up", sw.up, 1);
    check("rst_running", sw.running, 0);
    check("rst_load", sw.load, 0);
    clr = 0;
    step();
    check("cnt_clr_first_edge", sw.cnt_clr, 1);
    step();
    check("cnt_clr_second_edge", sw.cnt_clr, 0);

    // Start: running 7 cycles after raw edge, ce at +10/+20/+30.
    sw.strtstop = 1;
    rise = -1; n_ce = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 20) sw.strtstop = 0;
      if (sw.running && rise < 0) rise = k;
      if (sw.ce) begin
        if (n_ce < 4) ce_at[n_ce] = k;
        n_ce++;
      end
    end
    check("run_latency", rise, 7);
    check("ce_count", n_ce, 3);
    check("ce1_offset", ce_at[0] - rise, 10);
    check("ce2_offset", ce_at[1] - rise, 20);
    check("ce3_offset", ce_at[2] - rise, 30);

    // Bounce: toggles every 2 cycles never survive debounce.
    for (int k = 0; k < 12; k++) begin
      sw.strtstop = ((k / 2) % 2 == 0);
      step();
    end
    sw.strtstop = 0;
    repeat (10) step();
    check("bounce_running", sw.running, 1);

    // Stop exactly on the terminal count.
    wait_ce(seen);
    check("wait_ce", seen, 1);
    repeat (3) step();
    sw.strtstop = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("run_before_stop", sw.running, 1);
    end
    check("stop_tc_running", sw.running, 0);
    check("stop_tc_ce", sw.ce, 0);
    sw.strtstop = 0;
    repeat (12) step();

    // Restart: prescaler restarted from 0.
    sw.strtstop = 1;
    rise = -1; first_ce = -1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 10) sw.strtstop = 0;
      if (sw.running && rise < 0) rise = k;
      if (sw.ce && first_ce < 0) first_ce = k;
    end
    check("restart_ce_offset", first_ce - rise, 10);

    // rst_btn ignored in RUN.
    sw.rst_btn = 1;
    n_clr = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) sw.rst_btn = 0;
      if (sw.cnt_clr) n_clr++;
    end
    check("rst_in_run_clr", n_clr, 0);
    check("rst_in_run_running", sw.running, 1);

    press_ss();
    check("stopped", sw.running, 0);

    // STOP: rst_btn and strtstop together -> CLEAR wins.
    sw.rst_btn = 1; sw.strtstop = 1;
    n_clr = 0; clr_at = -1; n_run = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) begin sw.rst_btn = 0; sw.strtstop = 0; end
      if (sw.cnt_clr) begin n_clr++; if (clr_at < 0) clr_at = k; end
      if (sw.running) n_run++;
    end
    check("prio_clr_count", n_clr, 1);
    check("prio_clr_at", clr_at, 7);
    check("prio_running", n_run, 0);

    // Preset load / direction.
    sw.mode = 1;
    repeat (3) step();
    check("up_in_zero", sw.up, CD_EN ? 0 : 1);
    sw.load_btn = 1;
    n_load = 0; load_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) sw.load_btn = 0;
      if (sw.load) begin n_load++; if (load_at < 0) load_at = k; end
    end
    check("load_count", n_load, CD_EN ? 1 : 0);
    if (CD_EN) check("load_at", load_at, 7);
    check("load_running", sw.running, 0);
    press_ss();
    check("cd_running", sw.running, 1);
    sw.mode = 0;
    repeat (5) step();
    check("up_frozen_in_run", sw.up, CD_EN ? 0 : 1);
    press_ss();
    check("cd_stopped", sw.running, 0);
    check("up_after_stop", sw.up, 1);

    // Asynchronous reset mid-run.
    press_ss();
    check("pre_async_running", sw.running, 1);
    #2 clr = 1;
    #1;
    check("async_running", sw.running, 0);
    check("async_cnt_clr", sw.cnt_clr, 1);
    check("async_ce", sw.ce, 0);
    check("async_up", sw.up, 1);
    step();
    clr = 0;
    step();
    check("async_clr_hold", sw.cnt_clr, 1);
    step();
    check("async_clr_done", sw.cnt_clr, 0);
    check("async_zero", sw.running, 0);

    // Randomized run: buttons held for random lengths (bounces and presses).
    h_ss = 0; h_rb = 0; h_lb = 0;
    for (int k = 0; k < 4000; k++) begin
      if (h_ss == 0) begin sw.strtstop = $urandom_range(0, 1); h_ss = $urandom_range(1, 14); end
      else h_ss--;
      if (h_rb == 0) begin sw.rst_btn = ($urandom_range(0, 3) == 0); h_rb = $urandom_range(1, 14); end
      else h_rb--;
      if (h_lb == 0) begin sw.load_btn = ($urandom_range(0, 2) == 0); h_lb = $urandom_range(1, 14); end
      else h_lb--;
      if ($urandom_range(0, 40) == 0) sw.mode = ~sw.mode;
      if ($urandom_range(0, 1500) == 0) begin
        clr = 1;
        step();
        clr = 0;
      end
      step();
    end
    sw.strtstop = 0; sw.rst_btn = 0; sw.load_btn = 0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
